mem_bus_arbiter: RTL and testbench

Sequencer and arbiter for the CPU's single memory port. Arbitrates between the instruction-fetch requester (IR <= M[MAR]) and the data/stack requester (MDR <= M[MAR], M[MAR] <= MDR). It drives the memory read/write strobes and waits for the memory-function-complete (MFC) handshake. It returns read data with a one-cycle acknowledge, so the control FSM can issue memory states without owning the strobe/MFC protocol.

---
 rtl/memarb_pkg.sv | 19 +
 rtl/memarb_rr_pick.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package memarb_pkg;

   // Sequencer states for one memory transaction
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } memarb_state_t;

   // Port identifiers, also used for the round-robin "last served" flag
   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   // Default bus widths
   localparam int MEMARB_AW = 16;
   localparam int MEMARB_DW = 16;

endpackage

// File: rtl/memarb_rr_pick.sv
// Two-way round-robin pick between the fetch and data requesters.
module memarb_rr_pick
   import memarb_pkg::*;
(
   input  logic f_req,
   input  logic d_req,
   input  logic last,
   output logic gnt_vld,
   output logic gnt_owner
);

   // On a tie the port that was not served last wins, so neither waits twice
   always_comb begin
      gnt_vld   = f_req | d_req;
      gnt_owner = PORT_FETCH;
      if (f_req && d_req) begin
         gnt_owner = (last == PORT_DATA) ? PORT_FETCH : PORT_DATA;
      end else if (d_req) begin
         gnt_owner = PORT_DATA;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory-port sequencer/arbiter: grants fetch or data access, drives the
// rd/wr strobes, waits for MFC and returns a one-cycle ack with read data.
// Optional access timeout compiled in with `MEMARB_TIMEOUT_EN.
module mem_bus_arbiter
   import memarb_pkg::*;
#(
   parameter int AW      = MEMARB_AW,
   parameter int DW      = MEMARB_DW,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mfc
);

   memarb_state_t state_q, state_d;
   logic          last_q, last_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic          f_ack_q, f_ack_d;
   logic          d_ack_q, d_ack_d;
   logic          busy_q, busy_d;
   logic          mem_rd_q, mem_rd_d;
   logic          mem_wr_q, mem_wr_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          gnt_vld, gnt_owner;

`ifdef MEMARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   memarb_rr_pick u_pick (
      .f_req     (f_req),
      .d_req     (d_req),
      .last      (last_q),
      .gnt_vld   (gnt_vld),
      .gnt_owner (gnt_owner)
   );

   // Next-state and registered-output logic for the transaction sequencer
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      we_d        = we_q;
      f_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
`ifdef MEMARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d     = ACCESS;
               owner_d     = gnt_owner;
               we_d        = (gnt_owner == PORT_DATA) && d_we;
               mem_addr_d  = (gnt_owner == PORT_DATA) ? d_addr : f_addr;
               mem_wdata_d = ((gnt_owner == PORT_DATA) && d_we) ? d_wdata : '0;
               mem_rd_d    = !((gnt_owner == PORT_DATA) && d_we);
               mem_wr_d    = (gnt_owner == PORT_DATA) && d_we;
`ifdef MEMARB_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         ACCESS: begin
            if (mfc) begin
               state_d  = COMPLETE;
               last_d   = owner_q;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               rdata_d  = we_q ? '0 : mem_rdata;
               f_ack_d  = (owner_q == PORT_FETCH);
               d_ack_d  = (owner_q == PORT_DATA);
            end
`ifdef MEMARB_TIMEOUT_EN
            // The cycle that would bring the count to TIMEOUT aborts instead
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d  = COMPLETE;
               last_d   = owner_q;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               rdata_d  = '0;
               err_d    = 1'b1;
               f_ack_d  = (owner_q == PORT_FETCH);
               d_ack_d  = (owner_q == PORT_DATA);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         COMPLETE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers, all cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= PORT_DATA;
         owner_q     <= PORT_FETCH;
         we_q        <= 1'b0;
         f_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         busy_q      <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         f_ack_q     <= f_ack_d;
         d_ack_q     <= d_ack_d;
         busy_q      <= busy_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef MEMARB_TIMEOUT_EN
   // Access-cycle counter and abort flag for the timeout path
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign f_ack     = f_ack_q;
   assign d_ack     = d_ack_q;
   assign busy      = busy_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with an ack scoreboard.
module tb_mem_bus_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          f_req, d_req, d_we, mfc;
   logic [AW-1:0] f_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic          f_ack, d_ack, err, busy, mem_rd, mem_wr;
   logic [DW-1:0] rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   typedef struct packed {
      logic          owner;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_ack     (f_ack),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .rdata     (rdata),
      .err       (err),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata),
      .mfc       (mfc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic exp_t mk(input logic owner, input logic [DW-1:0] rd, input logic e);
      exp_t x;
      x.owner = owner;
      x.rdata = rd;
      x.err   = e;
      return x;
   endfunction

   // Wait for a strobe (bounded), check its address, answer with mfc for one cycle
   task automatic serve(input logic [AW-1:0] addr, input logic [DW-1:0] rd, output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!(mem_rd || mem_wr) && waited < 20);
      check("serve_strobe", 32'(mem_rd || mem_wr), 1);
      check("serve_addr", 32'(mem_addr), 32'(addr));
      mem_rdata = rd;
      mfc       = 1'b1;
      @(negedge clk);
      mfc       = 1'b0;
   endtask

   // Scoreboard: every ack pops one expected completion
   always @(negedge clk) begin
      exp_t e;
      if (f_ack || d_ack) begin
         if (sb_q.size() == 0) begin
            check("unexpected_ack", 32'({f_ack, d_ack}), 0);
         end else begin
            e = sb_q.pop_front();
            check("ack_owner", 32'({f_ack, d_ack}), e.owner ? 32'h1 : 32'h2);
            check("ack_rdata", 32'(rdata), 32'(e.rdata));
            check("ack_err", 32'(err), 32'(e.err));
         end
      end
   end

   initial begin
      int w;
      int cnt;
      reset = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mfc = 1'b0;
      f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_acks", 32'({f_ack, d_ack, err}), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_strobes", 32'({mem_rd, mem_wr}), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_wdata", 32'(mem_wdata), 0);
      check("rst_rdata", 32'(rdata), 0);
      reset = 1'b1;

      // Fetch read, mfc after two access cycles
      @(negedge clk);
      f_req = 1'b1; f_addr = 16'h0040;
      sb_q.push_back(mk(1'b0, 16'h1380, 1'b0));
      @(negedge clk);
      check("t1_rd_c1", 32'(mem_rd), 1);
      check("t1_addr", 32'(mem_addr), 32'h0040);
      check("t1_busy", 32'(busy), 1);
      @(negedge clk);
      check("t1_rd_c2", 32'(mem_rd), 1);
      mem_rdata = 16'h1380; mfc = 1'b1;
      @(negedge clk);
      mfc = 1'b0;
      check("t1_rd_off", 32'(mem_rd), 0);
      check("t1_fack", 32'(f_ack), 1);
      check("t1_dack", 32'(d_ack), 0);
      f_req = 1'b0;
      @(negedge clk);
      check("t1_fack_off", 32'(f_ack), 0);
      check("t1_idle", 32'(busy), 0);

      // Data write, mfc in first access cycle
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00FE; d_wdata = 16'hBEEF;
      sb_q.push_back(mk(1'b1, 16'h0000, 1'b0));
      @(negedge clk);
      check("t2_wr", 32'({mem_rd, mem_wr}), 32'h1);
      check("t2_addr", 32'(mem_addr), 32'h00FE);
      check("t2_wdata", 32'(mem_wdata), 32'hBEEF);
      mem_rdata = 16'h5555; mfc = 1'b1;
      @(negedge clk);
      mfc = 1'b0;
      check("t2_wr_off", 32'(mem_wr), 0);
      check("t2_dack", 32'(d_ack), 1);
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      check("t2_dack_off", 32'(d_ack), 0);
      check("t2_idle", 32'(busy), 0);

      // Tie out of reset, both held: F, D, F, D at 3 cycles each
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0100; d_addr = 16'h0200;
      sb_q.push_back(mk(1'b0, 16'hA001, 1'b0));
      sb_q.push_back(mk(1'b1, 16'hA002, 1'b0));
      sb_q.push_back(mk(1'b0, 16'hA003, 1'b0));
      sb_q.push_back(mk(1'b1, 16'hA004, 1'b0));
      serve(16'h0100, 16'hA001, w);
      serve(16'h0200, 16'hA002, w);
      check("t3_gap2", 32'(w), 2);
      serve(16'h0100, 16'hA003, w);
      check("t3_gap3", 32'(w), 2);
      serve(16'h0200, 16'hA004, w);
      check("t3_gap4", 32'(w), 2);
      f_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("t3_idle", 32'(busy), 0);

      // Address latched at grant; mfc in IDLE ignored
      f_req = 1'b1; f_addr = 16'h0300;
      sb_q.push_back(mk(1'b0, 16'h0BAD, 1'b0));
      @(negedge clk);
      f_addr = 16'h03FF;
      check("t4_addr", 32'(mem_addr), 32'h0300);
      @(negedge clk);
      check("t4_addr_hold", 32'(mem_addr), 32'h0300);
      serve(16'h0300, 16'h0BAD, w);
      f_req = 1'b0;
      @(negedge clk);
      mfc = 1'b1;
      @(negedge clk);
      mfc = 1'b0;
      check("t4_mfc_idle_busy", 32'(busy), 0);
      check("t4_mfc_idle_rd", 32'(mem_rd), 0);
      @(negedge clk);
      check("t4_mfc_idle_busy2", 32'(busy), 0);

      // Reset in the middle of an access
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0055;
      @(negedge clk);
      check("t5_rd", 32'(mem_rd), 1);
      #2 reset = 1'b0;
      #1;
      check("t5_rd_drop", 32'(mem_rd), 0);
      check("t5_busy_drop", 32'(busy), 0);
      check("t5_addr_clr", 32'(mem_addr), 0);
      @(negedge clk);
      reset = 1'b1;
      sb_q.push_back(mk(1'b1, 16'h0077, 1'b0));
      serve(16'h0055, 16'h0077, w);
      check("t5_restart_lat", 32'(w), 1);
      d_req = 1'b0;
      @(negedge clk);
      check("t5_idle", 32'(busy), 0);

`ifdef MEMARB_TIMEOUT_EN
      // No mfc: abort after 4 strobe cycles with err
      f_req = 1'b1; f_addr = 16'h0400;
      sb_q.push_back(mk(1'b0, 16'h0000, 1'b1));
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (f_ack) break;
         if (mem_rd) cnt++;
      end
      check("to_cycles", 32'(cnt), 4);
      check("to_ack", 32'(f_ack), 1);
      f_req = 1'b0;
      @(negedge clk);

      // mfc on the last allowed cycle wins
      f_req = 1'b1;
      sb_q.push_back(mk(1'b0, 16'hAAAA, 1'b0));
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (f_ack) break;
         if (mem_rd) begin
            cnt++;
            if (cnt == 4) begin
               mem_rdata = 16'hAAAA;
               mfc       = 1'b1;
            end
         end
      end
      mfc = 1'b0;
      check("to_mfc_cycles", 32'(cnt), 4);
      check("to_mfc_ack", 32'(f_ack), 1);
      f_req = 1'b0;
      @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
